// File: rtl/mvu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mvu_pkg: shared MVU types and precision helpers.  Rev 1.0
// ----------------------------------------------------------------------------
package mvu_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } bitser_state_e;

    function automatic int pb_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Precision 0 is treated as 1 and anything above the word width as the width.
    function automatic int prec_norm(input int prec, input int w);
        if (prec < 1) begin
            return 1;
        end
        if (prec > w) begin
            return w;
        end
        return prec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bitser_slot.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bitser_slot: pending word data/precision register pair.  Rev 1.0
// ----------------------------------------------------------------------------
module bitser_slot #(
    parameter int W  = 16,
    parameter int PB = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic [W-1:0]  i_data,
    input  logic [PB-1:0] i_prec,
    output logic [W-1:0]  o_data,
    output logic [PB-1:0] o_prec
);

    logic [W-1:0]  r_data;
    logic [PB-1:0] r_prec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_prec <= '0;
        end else if (i_clr) begin
            r_data <= '0;
            r_prec <= '0;
        end else if (i_load) begin
            r_data <= i_data;
            r_prec <= i_prec;
        end
    end

    assign o_data = r_data;
    assign o_prec = r_prec;

endmodule
`default_nettype wire

// File: rtl/bitser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bitser: parallel-to-serial word serializer, MSB-first, one-entry pending slot.  Rev 1.0
// ----------------------------------------------------------------------------
module bitser
    import mvu_pkg::*;
#(
    parameter int W  = 16,
    parameter int PB = pb_width(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [PB-1:0] in_prec,
    input  logic          out_en,
    output logic          out_bit,
    output logic          out_step,
    output logic          out_first,
    output logic          out_last,
    output logic          busy
);

    logic [W-1:0]  r_act_sreg;
    logic [PB-1:0] r_act_cnt;
    logic          r_act_valid;
    logic          r_act_first;
    logic          r_pend_valid;

    logic [W-1:0]  w_pend_data;
    logic [PB-1:0] w_pend_prec;
    bitser_state_e w_state;
    logic          w_last;
    logic          w_step;
    logic          w_retire;
    logic          w_accept;
    logic          w_to_act;
    logic          w_to_pend;
    logic          w_load;
    logic [PB-1:0] w_in_prec;
    logic [PB-1:0] w_ld_prec;
    logic [PB-1:0] w_ld_shamt;
    logic [W-1:0]  w_ld_data;
    logic [W-1:0]  w_ld_sreg;

    assign w_state   = r_act_valid ? ST_SHIFT : ST_IDLE;
    assign w_last    = (r_act_cnt == '0);
    assign w_step    = (w_state == ST_SHIFT) & out_en;
    assign w_retire  = w_step & w_last;
    assign w_accept  = in_valid & in_ready;
    // A word bypasses pending whenever the active slot is free on this edge.
    assign w_to_act  = w_accept & (~r_act_valid | w_retire);
    assign w_to_pend = w_accept & ~w_to_act;
    assign w_load    = w_to_act | (w_retire & r_pend_valid);

    assign w_in_prec  = PB'(prec_norm(int'(in_prec), W));
    assign w_ld_data  = w_to_act ? in_data : w_pend_data;
    assign w_ld_prec  = w_to_act ? w_in_prec : w_pend_prec;
    assign w_ld_shamt = PB'(W) - w_ld_prec;
    assign w_ld_sreg  = w_ld_data << w_ld_shamt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_sreg  <= '0;
            r_act_cnt   <= '0;
            r_act_valid <= 1'b0;
            r_act_first <= 1'b0;
        end else if (clr) begin
            r_act_sreg  <= '0;
            r_act_cnt   <= '0;
            r_act_valid <= 1'b0;
            r_act_first <= 1'b0;
        end else if (w_load) begin
            r_act_sreg  <= w_ld_sreg;
            r_act_cnt   <= w_ld_prec - PB'(1);
            r_act_valid <= 1'b1;
            r_act_first <= 1'b1;
        end else if (w_retire) begin
            r_act_valid <= 1'b0;
            r_act_first <= 1'b0;
        end else if (w_step) begin
            r_act_sreg  <= {r_act_sreg[W-2:0], 1'b0};
            r_act_cnt   <= r_act_cnt - PB'(1);
            r_act_first <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
        end else if (clr) begin
            r_pend_valid <= 1'b0;
        end else if (w_to_pend) begin
            r_pend_valid <= 1'b1;
        end else if (w_retire) begin
            r_pend_valid <= 1'b0;
        end
    end

    bitser_slot #(
        .W  (W),
        .PB (PB)
    ) u_pend (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (clr),
        .i_load (w_to_pend),
        .i_data (in_data),
        .i_prec (w_in_prec),
        .o_data (w_pend_data),
        .o_prec (w_pend_prec)
    );

    assign in_ready  = ~r_pend_valid;
    assign out_step  = w_step;
    assign out_bit   = r_act_valid & r_act_sreg[W-1];
    assign out_first = r_act_valid & r_act_first;
    assign out_last  = r_act_valid & w_last;
    assign busy      = r_act_valid | r_pend_valid;

endmodule
`default_nettype wire

// File: tb/tb_bitser.sv
`default_nettype none
// tb_bitser: scoreboard bench for the bit-serial word serializer.
module tb_bitser;

    localparam int W  = 16;
    localparam int PB = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [PB-1:0] in_prec = '0;
    logic          out_en = 1'b0;
    logic          out_bit;
    logic          out_step;
    logic          out_first;
    logic          out_last;
    logic          busy;

    typedef struct {
        logic b;
        logic f;
        logic l;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] wq_data[$];
    int           wq_prec[$];
    logic         obs_q[$];
    logic         dl_q[$];
    int           n_checks = 0;
    int           n_pass = 0;
    bit           saw_ready_low;
    logic [4:0]   r_dl;
    logic         dl_clr = 1'b1;

    bitser #(.W(W), .PB(PB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_prec   (in_prec),
        .out_en    (out_en),
        .out_bit   (out_bit),
        .out_step  (out_step),
        .out_first (out_first),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Downstream N=5 delay line advanced by out_step.
    always @(posedge clk) begin
        if (dl_clr) r_dl <= '0;
        else if (out_step) r_dl <= {r_dl[3:0], out_bit};
    end

    task automatic push_word(input logic [W-1:0] d, input int p);
        int n;
        n = (p < 1) ? 1 : ((p > W) ? W : p);
        for (int i = n - 1; i >= 0; i--)
            exp_q.push_back('{b: d[i], f: (i == n - 1), l: (i == 0)});
    endtask

    // Streams the words queued in wq_* with in_valid held and out_en=1.
    task automatic stream(input string tag, input int maxcyc);
        exp_t e;
        bit   acc;
        int   c;
        saw_ready_low = 0;
        out_en = 1'b1;
        for (c = 0; c < maxcyc; c++) begin
            if (!in_valid && wq_data.size() > 0) begin
                in_data  = wq_data.pop_front();
                in_prec  = PB'(wq_prec.pop_front());
                in_valid = 1'b1;
            end
            acc = in_valid && in_ready;
            if (acc) push_word(in_data, int'(in_prec));
            @(negedge clk);
            if (acc) in_valid = 1'b0;
            if (!in_ready) saw_ready_low = 1;
            n_checks++;
            if (out_step !== (exp_q.size() > 0))
                $display("FAIL %s step: got %b required %b", tag, out_step, exp_q.size() > 0);
            else n_pass++;
            if (out_step && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                obs_q.push_back(out_bit);
                dl_q.push_back(r_dl[4]);
                n_checks++;
                if ({out_bit, out_first, out_last} !== {e.b, e.f, e.l})
                    $display("FAIL %s bit/first/last: got %b%b%b required %b%b%b",
                             tag, out_bit, out_first, out_last, e.b, e.f, e.l);
                else n_pass++;
            end
            if (exp_q.size() == 0 && wq_data.size() == 0 && !in_valid) break;
        end
        n_checks++;
        if (c >= maxcyc) $display("FAIL %s timeout: got %0d cycles required <%0d", tag, c, maxcyc);
        else n_pass++;
    endtask

    task automatic test_reset();
        out_en = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({in_ready, out_bit, out_step, out_first, out_last, busy} !== 6'b100000)
            $display("FAIL reset outputs: got %b required 100000",
                     {in_ready, out_bit, out_step, out_first, out_last, busy});
        else n_pass++;
        rst_n = 1'b1;
        dl_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [7:0] ref_bits;
        ref_bits = 8'b10110101;
        obs_q.delete();
        wq_data.push_back(16'h00B5); wq_prec.push_back(8);
        stream("single", 40);
        n_checks++;
        if (obs_q.size() != 8) $display("FAIL single count: got %0d required 8", obs_q.size());
        else n_pass++;
        for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== ref_bits[7-i])
                $display("FAIL single bit%0d: got %b required %b", i, obs_q[i], ref_bits[7-i]);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if ({busy, out_step, in_ready} !== 3'b001)
            $display("FAIL single idle: got busy/step/ready %b required 001", {busy, out_step, in_ready});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] ref_bits;
        ref_bits = 5'b11101;
        obs_q.delete();
        wq_data.push_back(16'h0003); wq_prec.push_back(2);
        wq_data.push_back(16'h0005); wq_prec.push_back(3);
        stream("b2b", 40);
        n_checks++;
        if (saw_ready_low !== 1'b1) $display("FAIL b2b ready drop: got %b required 1", saw_ready_low);
        else n_pass++;
        n_checks++;
        if (obs_q.size() != 5) $display("FAIL b2b count: got %0d required 5", obs_q.size());
        else n_pass++;
        for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== ref_bits[4-i])
                $display("FAIL b2b bit%0d: got %b required %b", i, obs_q[i], ref_bits[4-i]);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL b2b busy: got %b required 0", busy);
        else n_pass++;
    endtask

    task automatic test_stall();
        exp_t e;
        int   c;
        exp_q.delete();
        out_en = 1'b1;
        in_data = 16'h000B; in_prec = PB'(4); in_valid = 1'b1;
        push_word(16'h000B, 4);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({out_step, out_bit, out_first, out_last} !== {1'b1, e.b, e.f, e.l})
                $display("FAIL stall pre%0d: got %b required %b", k,
                         {out_step, out_bit, out_first, out_last}, {1'b1, e.b, e.f, e.l});
            else n_pass++;
            @(negedge clk);
        end
        // Freeze mid-word while a second word slips into the pending slot.
        out_en = 1'b0;
        in_data = 16'h0002; in_prec = PB'(2); in_valid = 1'b1;
        push_word(16'h0002, 2);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (out_step !== 1'b0 || (k > 0 && in_ready !== 1'b0) ||
                {out_bit, out_first, out_last} !== {exp_q[0].b, exp_q[0].f, exp_q[0].l})
                $display("FAIL stall hold%0d: got step/ready/bfl %b %b %b required 0 %b %b", k,
                         out_step, in_ready, {out_bit, out_first, out_last}, (k == 0),
                         {exp_q[0].b, exp_q[0].f, exp_q[0].l});
            else n_pass++;
            @(negedge clk);
            in_valid = 1'b0;
        end
        out_en = 1'b1;
        for (c = 0; c < 20 && exp_q.size() > 0; c++) begin
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({out_step, out_bit, out_first, out_last} !== {1'b1, e.b, e.f, e.l})
                $display("FAIL stall resume%0d: got %b required %b", c,
                         {out_step, out_bit, out_first, out_last}, {1'b1, e.b, e.f, e.l});
            else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if (busy !== 1'b0 || c >= 20) $display("FAIL stall end: got busy %b cycles %0d required 0 <20", busy, c);
        else n_pass++;
    endtask

    task automatic test_boundary();
        obs_q.delete();
        wq_data.push_back(16'h0001); wq_prec.push_back(0);
        wq_data.push_back(16'hA5C3); wq_prec.push_back(31);
        stream("boundary", 60);
        n_checks++;
        if (obs_q.size() != 17) $display("FAIL boundary count: got %0d required 17", obs_q.size());
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_abort(input bit use_rst);
        string tag;
        tag = use_rst ? "abort_rst" : "abort_clr";
        exp_q.delete();
        out_en = 1'b1;
        in_data = 16'h00AB; in_prec = PB'(8); in_valid = 1'b1;
        @(negedge clk);
        in_data = 16'h000F; in_prec = PB'(4);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({in_ready, busy, out_step, out_first} !== 4'b0110)
            $display("FAIL %s setup: got %b required 0110", tag, {in_ready, busy, out_step, out_first});
        else n_pass++;
        if (!use_rst) begin
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
        end else begin
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
        end
        n_checks++;
        if ({in_ready, out_bit, out_step, out_first, out_last, busy} !== 6'b100000)
            $display("FAIL %s cleared: got %b required 100000", tag,
                     {in_ready, out_bit, out_step, out_first, out_last, busy});
        else n_pass++;
        if (use_rst) begin
            @(negedge clk);
            rst_n = 1'b1;
        end
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_bit, out_step, out_first, out_last, busy} !== 6'b100000)
            $display("FAIL %s quiet: got %b required 100000", tag,
                     {in_ready, out_bit, out_step, out_first, out_last, busy});
        else n_pass++;
        obs_q.delete();
        wq_data.push_back(16'h0005); wq_prec.push_back(3);
        stream(tag, 20);
        @(negedge clk);
    endtask

    task automatic test_shiftreg();
        logic [W-1:0] d[2];
        int           p[2];
        logic         ref_q[$];
        d[0] = 16'h035A; p[0] = 12;
        d[1] = 16'h000F; p[1] = 6;
        dl_clr = 1'b1;
        @(negedge clk);
        dl_clr = 1'b0;
        obs_q.delete(); dl_q.delete();
        for (int w = 0; w < 2; w++) begin
            wq_data.push_back(d[w]); wq_prec.push_back(p[w]);
            for (int i = p[w] - 1; i >= 0; i--) ref_q.push_back(d[w][i]);
        end
        stream("shiftreg", 60);
        n_checks++;
        if (dl_q.size() != 18) $display("FAIL shiftreg count: got %0d required 18", dl_q.size());
        else n_pass++;
        for (int k = 5; k < dl_q.size() && k < 18; k++) begin
            n_checks++;
            if (dl_q[k] !== ref_q[k-5])
                $display("FAIL shiftreg step%0d: got %b required %b", k, dl_q[k], ref_q[k-5]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_boundary();
        test_abort(1'b0);
        test_abort(1'b1);
        test_shiftreg();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/bitser.md
# bitser

Bit-serial word serializer that feeds the MVU bit-serial datapath (shift-register delay lines and bit-serial MAC lanes). It accepts parallel operand words over a valid/ready handshake with a per-word runtime precision. It emits each word's low `prec` bits MSB-first, one bit per enabled cycle, along with a step strobe and framing flags. A one-entry pending slot lets back-to-back words stream with no bubble.

## Interface
- `W`, 16: maximum word width in bits; legal range is 2..64.
- `PB`, `$clog2(W+1)`: width of the precision field.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clr` input 1: synchronous flush; drops the active and pending words; same end state as reset.
- `in_valid` input 1: upstream word valid.
- `in_ready` output 1: block can accept a word; equals `!pend_valid`.
- `in_data` input W: parallel word; bits above `prec` are ignored.
- `in_prec` input PB: number of bits to emit. 0 is treated as 1. Values >W are treated as W.
- `out_en` input 1: downstream enable; a bit is consumed only in cycles where it is 1.
- `out_bit` output 1: current serial bit (MSB of the active window).
- `out_step` output 1: `active & out_en`; drives the `step` input of downstream shift registers.
- `out_first` output 1: current bit is the word's MSB.
- `out_last` output 1: current bit is the word's LSB (bit 0).
- `busy` output 1: active word or pending word present.

## Operation
- State held: an active slot (`act_sreg[W-1:0]`, `act_cnt`, `act_valid`, `act_first`) and a pending slot (`pend_data`, `pend_prec`, `pend_valid`). FSM states are derived:
  - IDLE: `!act_valid`.
  - SHIFT: `act_valid`.
- Load into active: the word is left-aligned as `act_sreg = data << (W-prec)`, with `act_cnt = prec-1` and `act_first = 1`.
- Handshake: a word is accepted on an edge where `in_valid & in_ready`.
  - If the active slot is empty, or is finishing its last bit on that same edge, the accepted word loads directly into active.
  - Otherwise it goes to pending.
- Step (`out_step = 1` on an edge):
  - `act_sreg <<= 1`, `act_cnt -= 1`, `act_first = 0`.
  - If `act_cnt == 0` (last bit), the active slot retires.
  - On retire, pending (if valid) moves to active on the same edge and pending empties. Otherwise active empties (→ IDLE).
- Outputs:
  - `out_bit = act_sreg[W-1]`.
  - `out_first = act_valid & act_first`.
  - `out_last = act_valid & (act_cnt == 0)`.
  - All are 0 when IDLE.
- A `prec = 1` word is both first and last in its single cycle.
- `out_en = 0`: all state frozen; handshake into pending remains legal if the pending slot is free.
- Simultaneous retire + accept with pending full: not possible, since `in_ready = 0`.
- Simultaneous retire + accept with pending empty: the new word goes to active; pending stays empty.
- `clr` overrides all other activity on that edge. Reset or `clr` mid-word aborts the word; no partial-word flags appear afterwards.
- Reset values: `in_ready = 1`; `out_bit`, `out_step`, `out_first`, `out_last`, `busy` all 0.

## Timing
- Latency: a word accepted at edge t presents its MSB on `out_bit` in the cycle after t.
- Word occupancy: exactly `prec` enabled cycles.
- Throughput: with `out_en` held at 1 and `in_valid` held at 1, output is gapless across word boundaries. `out_last` of word k is followed directly by `out_first` of word k+1.
- `in_ready` is registered-state-only: it never depends combinationally on `in_valid`.
- `out_step`, `out_bit` and the flags depend combinationally on `out_en` only through `out_step`.

## Structure
- Shared package `mvu_pkg` holds:
  - the precision width helper `PB(W)`;
  - the clamp function `prec_norm(prec, W)` (0→1, >W→W).
- A single sub-module `bitser_slot` (the pending data/precision register pair) is acceptable. Otherwise the block is a flat module.

## Test plan
- Single word: reset, then send `W=16`, `in_data = 0x00B5`, `prec = 8` with `out_en = 1`.
  - `out_bit` sequence is 1,0,1,1,0,1,0,1 over 8 cycles starting one cycle after acceptance.
  - `out_first` is set on bit 1 and `out_last` on bit 8.
  - `busy` falls after bit 8.
- Back-to-back: send words A=`0x3` (prec 2) and B=`0x5` (prec 3) with `in_valid` held.
  - Bit stream is 1,1,1,0,1 with no gap.
  - `in_ready` drops while both slots are full.
- Stall: during a prec=4 word, drop `out_en` for 3 cycles mid-word.
  - `out_bit` and the flags hold; `out_step = 0` during the stall.
  - Remaining bits resume unchanged.
- Boundary precision:
  - `prec = 0` on `0x1` emits a single bit 1 with first=last=1.
  - `prec = 31` on `W=16` emits 16 bits.
- Abort: assert `clr` (then separately pull `rst_n` low asynchronously, mid-clock) on the 2nd bit of a prec=8 word with a word pending.
  - Both slots clear; `in_ready = 1`; all outputs go to 0.
  - The next word starts cleanly with `out_first`.
- Shiftreg integration: drive a downstream `N = 5` delay line with `out_bit`/`out_step`.
  - Its output reproduces the serial stream delayed by exactly 5 steps.
